// File: rtl/led_matrix_scan_pkg.sv
// Shared definitions for the front-panel LED matrix scanner: mode encodings,
// default geometry, and width/dark-output helpers.
package led_matrix_scan_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_ACT   = 2'b11
   } led_mode_e;

   localparam int unsigned NX_DEF           = 4;
   localparam int unsigned NY_DEF           = 3;
   localparam int unsigned SLOTS_DEF        = 16;
   localparam int unsigned DWELL_BITS_DEF   = 16;
   localparam int unsigned BLANK_CYCLES_DEF = 64;
   localparam int unsigned BLINK_BITS_DEF   = 25;
   localparam int unsigned ACT_FRAMES_DEF   = 4;

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // NLED: number of LEDs in an NX x NY matrix
   function automatic int unsigned nled(input int unsigned nx, input int unsigned ny);
      return nx * ny;
   endfunction

   // SLOT_W: slot counter width
   function automatic int unsigned slot_w(input int unsigned slots);
      return clog2_min1(slots);
   endfunction

   // ACT_W: activity counter width, must hold 0..frames
   function automatic int unsigned act_w(input int unsigned frames);
      return clog2_min1(frames + 1);
   endfunction

   // Row lines are active-low, so dark is all ones on the low ny bits
   function automatic logic [31:0] dark_rows(input int unsigned ny);
      return (ny >= 32) ? '1 : ((32'd1 << ny) - 32'd1);
   endfunction

endpackage

// File: rtl/led_act_stretch.sv
// Per-LED activity stretcher: a pulse loads ACT_FRAMES, each frame end
// counts down, and idle_c reports when the count has run out.
module led_act_stretch
   import led_matrix_scan_pkg::*;
#(
   parameter int unsigned ACT_FRAMES = ACT_FRAMES_DEF,
   parameter int unsigned ACT_W      = act_w(ACT_FRAMES_DEF)
) (
   input  logic clk125m,
   input  logic rst_n,
   input  logic act,
   input  logic frame_end,
   output logic idle_c
);

   logic [ACT_W-1:0] cnt;

   // A new pulse always wins over the frame-end decrement
   always_ff @(posedge clk125m) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (act) begin
         cnt <= ACT_W'(ACT_FRAMES);
      end else if (frame_end && (cnt != '0)) begin
         cnt <= cnt - ACT_W'(1);
      end
   end

   assign idle_c = (cnt == '0);

endmodule

// File: rtl/led_matrix_scan.sv
// Time-multiplexed LED matrix scanner with blanking guard, blink and
// activity-stretched modes; one LED (at most) is driven per scan slot.
module led_matrix_scan
   import led_matrix_scan_pkg::*;
#(
   parameter int unsigned NX           = NX_DEF,
   parameter int unsigned NY           = NY_DEF,
   parameter int unsigned SLOTS        = SLOTS_DEF,
   parameter int unsigned DWELL_BITS   = DWELL_BITS_DEF,
   parameter int unsigned BLANK_CYCLES = BLANK_CYCLES_DEF,
   parameter int unsigned BLINK_BITS   = BLINK_BITS_DEF,
   parameter int unsigned ACT_FRAMES   = ACT_FRAMES_DEF
) (
   input  logic                 clk125m,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [2*NX*NY-1:0]   led_mode,
   input  logic [NX*NY-1:0]     led_act,
   output logic [NX-1:0]        scan_x,
   output logic [NY-1:0]        scan_y
);

   localparam int unsigned NUM_LED   = nled(NX, NY);
   localparam int unsigned SLOT_BITS = slot_w(SLOTS);
   localparam int unsigned ACT_BITS  = act_w(ACT_FRAMES);
   localparam logic [NY-1:0] ROW_DARK = NY'(dark_rows(NY));

   logic [DWELL_BITS-1:0] dwell;
   logic [SLOT_BITS-1:0]  slot;
   logic [BLINK_BITS-1:0] blink_cnt;

   led_mode_e mode_q;
   logic      blink_q;
   logic      idle_q;

   logic [NUM_LED-1:0] act_idle_c;
   logic               dwell_wrap_c;
   logic               frame_end_c;
   logic               slot_live_c;
   led_mode_e          sel_mode_c;
   logic               sel_idle_c;
   logic [NX-1:0]      col_c;
   logic [NY-1:0]      row_c;
   led_mode_e          cur_mode_c;
   logic               cur_blink_c;
   logic               cur_idle_c;
   logic               lit_c;
   logic               show_c;

   assign dwell_wrap_c = (dwell == '1);
   assign frame_end_c  = enable && dwell_wrap_c && (slot == SLOT_BITS'(SLOTS - 1));

   // Scan counters; disable parks the scan at slot 0, dwell 0
   always_ff @(posedge clk125m) begin
      if (!rst_n) begin
         dwell     <= '0;
         slot      <= '0;
         blink_cnt <= '0;
      end else begin
         blink_cnt <= blink_cnt + BLINK_BITS'(1);
         if (!enable) begin
            dwell <= '0;
            slot  <= '0;
         end else begin
            dwell <= dwell + DWELL_BITS'(1);
            if (dwell_wrap_c) begin
               slot <= (slot == SLOT_BITS'(SLOTS - 1)) ? '0 : slot + SLOT_BITS'(1);
            end
         end
      end
   end

   // Decode the addressed LED: x varies fastest, slots past the matrix stay dark
   always_comb begin
      slot_live_c = 1'b0;
      sel_mode_c  = MODE_OFF;
      sel_idle_c  = 1'b1;
      col_c       = '0;
      row_c       = ROW_DARK;
      for (int unsigned i = 0; i < NUM_LED; i++) begin
         if (slot == SLOT_BITS'(i)) begin
            slot_live_c = 1'b1;
            sel_mode_c  = led_mode_e'(led_mode[2*i +: 2]);
            sel_idle_c  = act_idle_c[i];
            col_c       = NX'(1) << (i % NX);
            row_c       = ~(NY'(1) << (i / NX));
         end
      end
   end

   // Slot-start snapshot of mode, blink phase and activity state
   always_ff @(posedge clk125m) begin
      if (!rst_n) begin
         mode_q  <= MODE_OFF;
         blink_q <= 1'b0;
         idle_q  <= 1'b0;
      end else if (dwell == '0) begin
         mode_q  <= sel_mode_c;
         blink_q <= blink_cnt[BLINK_BITS-1];
         idle_q  <= sel_idle_c;
      end
   end

   always_comb begin
      cur_mode_c  = mode_q;
      cur_blink_c = blink_q;
      cur_idle_c  = idle_q;
      if (dwell == '0) begin
         cur_mode_c  = sel_mode_c;
         cur_blink_c = blink_cnt[BLINK_BITS-1];
         cur_idle_c  = sel_idle_c;
      end
      unique case (cur_mode_c)
         MODE_OFF:   lit_c = 1'b0;
         MODE_ON:    lit_c = 1'b1;
         MODE_BLINK: lit_c = cur_blink_c;
         MODE_ACT:   lit_c = cur_idle_c;
      endcase
      show_c = enable && slot_live_c && (dwell >= DWELL_BITS'(BLANK_CYCLES)) && lit_c;
   end

   // Column and row registers always update together
   always_ff @(posedge clk125m) begin
      if (!rst_n) begin
         scan_x <= '0;
         scan_y <= ROW_DARK;
      end else if (show_c) begin
         scan_x <= col_c;
         scan_y <= row_c;
      end else begin
         scan_x <= '0;
         scan_y <= ROW_DARK;
      end
   end

   for (genvar i = 0; i < NUM_LED; i++) begin : g_act
      led_act_stretch #(
         .ACT_FRAMES (ACT_FRAMES),
         .ACT_W      (ACT_BITS)
      ) u_act (
         .clk125m   (clk125m),
         .rst_n     (rst_n),
         .act       (led_act[i]),
         .frame_end (frame_end_c),
         .idle_c    (act_idle_c[i])
      );
   end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed and randomised checks of led_matrix_scan with a 4-cycle slot,
// 64-cycle frame, 64-cycle blink period and 2-frame activity stretch.
module tb_led_matrix_scan;

   localparam int unsigned NX   = 4;
   localparam int unsigned NY   = 3;
   localparam int unsigned NLED = NX * NY;

   logic              clk125m = 1'b0;
   logic              rst_n;
   logic              enable;
   logic [2*NLED-1:0] led_mode;
   logic [NLED-1:0]   led_act;
   logic [NX-1:0]     scan_x;
   logic [NY-1:0]     scan_y;

   int n_cmp = 0;
   int n_err = 0;

   logic [3:0] x_tab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
   logic [2:0] y_tab [3] = '{3'b110, 3'b101, 3'b011};

   // Reference model state (values seen before the next clock edge)
   int         m_dw    = 0;
   int         m_sl    = 0;
   int         m_blink = 0;
   int         m_act [NLED];
   bit         m_lit   = 1'b0;
   logic [3:0] m_x     = 4'b0000;
   logic [2:0] m_y     = 3'b111;

   led_matrix_scan #(
      .NX           (4),
      .NY           (3),
      .SLOTS        (16),
      .DWELL_BITS   (2),
      .BLANK_CYCLES (1),
      .BLINK_BITS   (6),
      .ACT_FRAMES   (2)
   ) dut (
      .clk125m  (clk125m),
      .rst_n    (rst_n),
      .enable   (enable),
      .led_mode (led_mode),
      .led_act  (led_act),
      .scan_x   (scan_x),
      .scan_y   (scan_y)
   );

   always #4 clk125m = ~clk125m;

   function automatic bit decide(input int s);
      logic [1:0] md;
      md = led_mode[2*s +: 2];
      case (md)
         2'b00:   return 1'b0;
         2'b01:   return 1'b1;
         2'b10:   return ((m_blink >> 5) & 1) != 0;
         default: return m_act[s] == 0;
      endcase
   endfunction

   task automatic model_step();
      bit ln;
      bit fe;
      if (!rst_n) begin
         m_dw = 0; m_sl = 0; m_blink = 0; m_lit = 1'b0;
         for (int i = 0; i < NLED; i++) m_act[i] = 0;
         m_x = 4'b0000; m_y = 3'b111;
         return;
      end
      ln = 1'b0;
      if (m_sl < NLED) ln = (m_dw == 0) ? decide(m_sl) : m_lit;
      if (enable && m_sl < NLED && m_dw >= 1 && ln) begin
         m_x = 4'(1 << (m_sl % 4));
         m_y = ~3'(1 << (m_sl / 4));
      end else begin
         m_x = 4'b0000;
         m_y = 3'b111;
      end
      if (m_dw == 0) m_lit = ln;
      fe = enable && m_dw == 3 && m_sl == 15;
      for (int i = 0; i < NLED; i++) begin
         if (led_act[i]) m_act[i] = 2;
         else if (fe && m_act[i] > 0) m_act[i] = m_act[i] - 1;
      end
      m_blink = (m_blink + 1) % 64;
      if (enable) begin
         if (m_dw == 3) begin
            m_dw = 0;
            m_sl = (m_sl + 1) % 16;
         end else begin
            m_dw = m_dw + 1;
         end
      end else begin
         m_dw = 0;
         m_sl = 0;
      end
   endtask

   // One clock: advance model, wait past the edge, compare against the model
   task automatic tick();
      model_step();
      @(posedge clk125m);
      #1;
      n_cmp++;
      assert ({scan_x, scan_y} === {m_x, m_y}) else begin
         n_err++;
         $error("FAIL model: scan_x=%b scan_y=%b expected %b %b", scan_x, scan_y, m_x, m_y);
      end
   endtask

   task automatic check(input string tag, input logic [3:0] ex, input logic [2:0] ey);
      n_cmp++;
      assert ({scan_x, scan_y} === {ex, ey}) else begin
         n_err++;
         $error("FAIL %s: scan_x=%b scan_y=%b expected %b %b", tag, scan_x, scan_y, ex, ey);
      end
   endtask

   // All LEDs on: slot k/4 lit on dwell 1..3 for the first 12 slots
   task automatic run_all_on(input string tag, input int nk);
      for (int k = 0; k < nk; k++) begin
         tick();
         if ((k % 4) != 0 && (k / 4) < 12) check(tag, x_tab[(k/4) % 4], y_tab[(k/4) / 4]);
         else check(tag, 4'b0000, 3'b111);
      end
   endtask

   // One frame where only lit_slot may show; optional act[0] pulse and mode clear
   task automatic run_frame(input string tag, input int lit_slot, input int pulse, input int chg_at);
      for (int k = 0; k < 64; k++) begin
         led_act = (k == pulse) ? 12'h001 : 12'h000;
         tick();
         if (lit_slot >= 0 && (k / 4) == lit_slot && (k % 4) != 0)
            check(tag, x_tab[lit_slot % 4], y_tab[lit_slot / 4]);
         else
            check(tag, 4'b0000, 3'b111);
         if (k == chg_at) led_mode = '0;
      end
      led_act = '0;
   endtask

   initial begin
      bit ok;
      for (int i = 0; i < NLED; i++) m_act[i] = 0;
      rst_n    = 1'b0;
      enable   = 1'b0;
      led_mode = '0;
      led_act  = '0;
      repeat (3) tick();
      check("reset", 4'b0000, 3'b111);

      // All on, full frame from slot 0
      led_mode = {NLED{2'b01}};
      rst_n    = 1'b1;
      enable   = 1'b1;
      run_all_on("all_on", 64);

      // Reset in slot 5
      run_all_on("pre_rst", 22);
      rst_n = 1'b0;
      tick();
      check("rst_dark", 4'b0000, 3'b111);
      tick();
      rst_n = 1'b1;
      tick();
      check("rst_guard", 4'b0000, 3'b111);
      tick();
      check("rst_slot0", 4'b0001, 3'b110);
      repeat (62) tick();

      // Blink on LED 6: phase low at its slot, then shifted 32 cycles to high
      led_mode        = '0;
      led_mode[13:12] = 2'b10;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      run_frame("blink_lo", -1, -1, -1);
      enable = 1'b0;
      for (int k = 0; k < 32; k++) begin
         tick();
         check("en_off", 4'b0000, 3'b111);
      end
      enable = 1'b1;
      run_frame("blink_hi", 6, -1, 25);
      run_frame("blink_chg", -1, -1, -1);

      // Activity stretch on LED 0
      led_mode      = '0;
      led_mode[1:0] = 2'b11;
      run_frame("act_a", 0, 40, -1);
      run_frame("act_b", -1, -1, -1);
      run_frame("act_c", 0, 40, -1);
      run_frame("act_d", -1, 40, -1);
      run_frame("act_e", -1, -1, -1);
      run_frame("act_f", 0, 63, -1);
      run_frame("act_g", -1, -1, -1);
      run_frame("act_h", -1, -1, -1);
      run_frame("act_i", 0, -1, -1);

      // Enable dropped in slot 3
      led_mode = {NLED{2'b01}};
      run_all_on("pre_dis", 14);
      enable = 1'b0;
      tick();
      check("dis_dark", 4'b0000, 3'b111);
      repeat (4) begin
         tick();
         check("dis_hold", 4'b0000, 3'b111);
      end
      enable = 1'b1;
      tick();
      check("re_guard", 4'b0000, 3'b111);
      tick();
      check("re_slot0", 4'b0001, 3'b110);

      // Random modes, pulses and enable drops
      for (int n = 0; n < 10000; n++) begin
         if ($urandom_range(63) == 0) led_mode = 24'($urandom);
         for (int i = 0; i < NLED; i++) led_act[i] = ($urandom_range(47) == 0);
         if (!enable) enable = ($urandom_range(7) == 0);
         else enable = ($urandom_range(399) != 0);
         tick();
         ok = $onehot0(scan_x) && (scan_y == 3'b111 || $onehot(~scan_y)) &&
              ((scan_x != 4'b0000) == (scan_y != 3'b111));
         n_cmp++;
         assert (ok === 1'b1) else begin
            n_err++;
            $error("FAIL shape: scan_x=%b scan_y=%b expected one-hot pair or dark", scan_x, scan_y);
         end
      end
      led_act = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
